// File: rtl/aes_key_schedule.sv
// Purpose: AES-128/192/256 key expansion into a 60x32 round-key store with a word stream and a registered read port.
// Latency: word w[k] is streamed k+1 cycles after start acceptance; done follows the last word by one cycle.
// Backpressure: none; the stream runs at one word per cycle and start is ignored while busy.
module aes_key_schedule #(
    parameter int MAX_KEY_BITS = 256,
    parameter int RD_LATENCY   = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   key_len,
    input  logic [255:0] key_in,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic         key_ready,
    output logic         rk_valid,
    output logic [5:0]   rk_idx,
    output logic [31:0]  rk_word,
    input  logic [5:0]   rd_addr,
    output logic [31:0]  rd_data
);

    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    state_t         state, state_nxt;
    logic [255:0]   key_q;
    logic [1:0]     len_q;
    logic [5:0]     idx_q;
    logic [2:0]     phase_q;      // i mod Nk
    logic [7:0]     rcon_q;
    logic [31:0]    win_q [0:7];  // win_q[0] = w[i-1], win_q[n-1] = w[i-n]
    logic [31:0]    mem   [0:59];
    logic           key_ready_q;
    logic           err_q;
    logic [31:0]    rd_s1;

    logic           start_ok;
    logic [2:0]     nk_last;
    logic [5:0]     total_last;
    logic [31:0]    temp, w_old, sw_in, sw_out, w_new;
    logic           in_key;

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box: multiplicative inverse (x^254, which maps 0 to 0) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] r;
        logic [7:0] b;
        sq = x;
        r  = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        b = r;
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic mode_bad(input logic [1:0] len);
        return (len == 2'd3) ||
               (len == 2'd1 && MAX_KEY_BITS < 192) ||
               (len == 2'd2 && MAX_KEY_BITS < 256);
    endfunction

    // Mode decode of the latched key length
    always_comb begin
        nk_last    = 3'd3;
        total_last = 6'd43;
        case (len_q)
            2'd1:    begin nk_last = 3'd5; total_last = 6'd51; end
            2'd2:    begin nk_last = 3'd7; total_last = 6'd59; end
            default: begin nk_last = 3'd3; total_last = 6'd43; end
        endcase
    end

    assign start_ok = start && !mode_bad(key_len);

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok) state_nxt = EXPAND;
            EXPAND:  if (idx_q == total_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Word generator: a single SubWord shared by the rotated and plain cases
    always_comb begin
        temp   = win_q[0];
        w_old  = win_q[nk_last];
        in_key = (idx_q <= {3'd0, nk_last});
        sw_in  = (phase_q == 3'd0) ? {temp[23:0], temp[31:24]} : temp;
        sw_out = {sbox(sw_in[31:24]), sbox(sw_in[23:16]), sbox(sw_in[15:8]), sbox(sw_in[7:0])};
        if (in_key)
            w_new = key_q[{~idx_q[2:0], 5'd0} +: 32];
        else if (phase_q == 3'd0)
            w_new = w_old ^ sw_out ^ {rcon_q, 24'h000000};
        else if (len_q == 2'd2 && phase_q == 3'd4)
            w_new = w_old ^ sw_out;
        else
            w_new = w_old ^ temp;
    end

    // Control state: FSM, counters, round constant, status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            len_q       <= 2'd0;
            idx_q       <= 6'd0;
            phase_q     <= 3'd0;
            rcon_q      <= 8'h01;
            key_ready_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state <= state_nxt;
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        key_ready_q <= 1'b0;
                        if (start_ok) begin
                            len_q   <= key_len;
                            idx_q   <= 6'd0;
                            phase_q <= 3'd0;
                            rcon_q  <= 8'h01;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                EXPAND: begin
                    idx_q   <= idx_q + 6'd1;
                    phase_q <= (phase_q == nk_last) ? 3'd0 : phase_q + 3'd1;
                    if (!in_key && phase_q == 3'd0)
                        rcon_q <= {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
                    if (idx_q == total_last)
                        key_ready_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Key capture and sliding window of the last eight words (no reset needed)
    always_ff @(posedge clk) begin
        if (state == IDLE && start_ok)
            key_q <= key_in;
        if (state == EXPAND) begin
            win_q[0] <= w_new;
            for (int j = 1; j < 8; j++)
                win_q[j] <= win_q[j-1];
        end
    end

    // Round-key storage write
    always_ff @(posedge clk) begin
        if (state == EXPAND)
            mem[idx_q] <= w_new;
    end

    // First read stage: out-of-range or stale schedule reads return zero
    always_ff @(posedge clk) begin
        if (rst)
            rd_s1 <= 32'd0;
        else if (key_ready_q && rd_addr <= total_last)
            rd_s1 <= mem[rd_addr];
        else
            rd_s1 <= 32'd0;
    end

    generate
        if (RD_LATENCY == 2) begin : g_rd2
            logic [31:0] rd_s2;
            // Optional second read stage
            always_ff @(posedge clk) begin
                if (rst) rd_s2 <= 32'd0;
                else     rd_s2 <= rd_s1;
            end
            assign rd_data = rd_s2;
        end else begin : g_rd1
            assign rd_data = rd_s1;
        end
    endgenerate

    assign busy      = (state == EXPAND);
    assign rk_valid  = busy;
    assign rk_idx    = busy ? idx_q : 6'd0;
    assign rk_word   = busy ? w_new : 32'd0;
    assign done      = (state == DONE);
    assign err       = err_q;
    assign key_ready = key_ready_q;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Purpose: randomized scoreboard bench for aes_key_schedule against a plain FIPS-197 key-expansion model.
// Latency: expects w[k] k cycles after the acceptance edge, done TOTAL cycles after it, err right after it.
// Backpressure: none; the monitor pops expectations whenever the DUT presents rk_valid, done or err.
module tb_aes_key_schedule;

    localparam int RDL = 1;

    logic         clk = 1'b0;
    logic         rst, start;
    logic [1:0]   key_len;
    logic [255:0] key_in;
    logic         busy, done, err, key_ready, rk_valid;
    logic [5:0]   rk_idx, rd_addr;
    logic [31:0]  rk_word, rd_data;

    aes_key_schedule #(.MAX_KEY_BITS(256), .RD_LATENCY(RDL)) dut (
        .clk(clk), .rst(rst), .start(start), .key_len(key_len), .key_in(key_in),
        .busy(busy), .done(done), .err(err), .key_ready(key_ready),
        .rk_valid(rk_valid), .rk_idx(rk_idx), .rk_word(rk_word),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    typedef struct {
        int          idx;
        logic [31:0] word;
        int          cyc;
    } exp_t;

    exp_t        sbq[$];
    int          dq[$];
    int          eq[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          busy_cnt = 0;
    logic [7:0]  sbt [0:255];
    logic [31:0] exp_w [0:59];
    int          exp_total = 0;
    bit          exp_valid = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // S-box table built by walking the multiplicative group with generator 3
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
            sbt[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbt[0] = 8'h63;
    endtask

    function automatic logic [31:0] subw(input logic [31:0] v);
        return {sbt[v[31:24]], sbt[v[23:16]], sbt[v[15:8]], sbt[v[7:0]]};
    endfunction

    task automatic build_model(input logic [255:0] key, input logic [1:0] len);
        logic [7:0]  rc [0:9];
        logic [31:0] t;
        int nk;
        rc = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
        nk = 4 + 2 * int'(len);
        exp_total = 4 * nk + 28;
        for (int i = 0; i < exp_total; i++) begin
            if (i < nk) begin
                exp_w[i] = key[255 - 32*i -: 32];
            end else begin
                t = exp_w[i-1];
                if (i % nk == 0)
                    t = subw({t[23:0], t[31:24]}) ^ {rc[i/nk - 1], 24'h0};
                else if (nk == 8 && i % 8 == 4)
                    t = subw(t);
                exp_w[i] = exp_w[i-nk] ^ t;
            end
        end
    endtask

    function automatic logic [255:0] rand_key();
        logic [255:0] k;
        for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
        return k;
    endfunction

    function automatic logic [31:0] rd_model(input int a);
        return (exp_valid && a < exp_total) ? exp_w[a] : 32'd0;
    endfunction

    // Monitor: pops and compares whenever the DUT presents an output event
    always @(negedge clk) begin
        exp_t e;
        if (busy) busy_cnt++;
        if (rk_valid) begin
            if (sbq.size() == 0) begin
                check("rk_unexpected", rk_valid, 0);
            end else begin
                e = sbq.pop_front();
                check("rk_idx", rk_idx, e.idx);
                check("rk_word", rk_word, e.word);
                check("rk_cycle", cyc, e.cyc);
            end
        end
        if (done) begin
            if (dq.size() == 0) check("done_unexpected", done, 0);
            else check("done_cycle", cyc, dq.pop_front());
        end
        if (err) begin
            if (eq.size() == 0) check("err_unexpected", err, 0);
            else check("err_cycle", cyc, eq.pop_front());
        end
    end

    task automatic issue(input logic [1:0] len, input logic [255:0] key, output int p);
        exp_t e;
        @(negedge clk);
        start   = 1'b1;
        key_len = len;
        key_in  = key;
        p = cyc + 1;
        busy_cnt = 0;
        if (len != 2'd3) begin
            build_model(key, len);
            for (int k = 0; k < exp_total; k++) begin
                e.idx = k; e.word = exp_w[k]; e.cyc = p + k;
                sbq.push_back(e);
            end
            dq.push_back(p + exp_total);
            exp_valid = 1'b1;
        end else begin
            eq.push_back(p);
            exp_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        start   = 1'b0;
        key_in  = rand_key();
        key_len = 2'($urandom_range(0, 3));
    endtask

    task automatic drain();
        for (int n = 0; n < 300; n++) begin
            if (sbq.size() == 0 && dq.size() == 0 && eq.size() == 0) break;
            @(negedge clk);
        end
        check("drain_timeout", sbq.size() + dq.size() + eq.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic rd_check(input int a, input logic [31:0] expv, input string nm);
        @(negedge clk);
        rd_addr = 6'(a);
        repeat (RDL) @(posedge clk);
        #1;
        check(nm, rd_data, expv);
    endtask

    task automatic check_idle_zero(input string nm);
        check({nm, "_busy"}, busy, 0);
        check({nm, "_done"}, done, 0);
        check({nm, "_err"}, err, 0);
        check({nm, "_key_ready"}, key_ready, 0);
        check({nm, "_rk_valid"}, rk_valid, 0);
        check({nm, "_rk_idx"}, rk_idx, 0);
        check({nm, "_rk_word"}, rk_word, 0);
        check({nm, "_rd_data"}, rd_data, 0);
    endtask

    initial begin
        int p;
        int a;
        logic [1:0] len;
        build_sbox();
        rst = 1'b1; start = 1'b0; key_len = 2'd0; key_in = '0; rd_addr = 6'd0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_zero("reset");
        rst = 1'b0;

        // AES-128 known answer
        issue(2'd0, 256'h2b7e151628aed2a6abf7158809cf4f3c << 128, p);
        drain();
        check("k128_key_ready", key_ready, 1);
        check("k128_busy_cycles", busy_cnt, 44);
        rd_check(4, 32'ha0fafe17, "k128_w4");
        rd_check(43, 32'hb6630ca6, "k128_w43");
        rd_check(50, 32'h0, "k128_rd_oob");

        // AES-192 known answer
        issue(2'd1, 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b << 64, p);
        drain();
        check("k192_busy_cycles", busy_cnt, 52);
        rd_check(6, 32'hfe0c91f7, "k192_w6");
        rd_check(51, 32'h01002202, "k192_w51");
        rd_check(52, 32'h0, "k192_rd_oob");

        // AES-256 known answer
        issue(2'd2, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, p);
        drain();
        check("k256_busy_cycles", busy_cnt, 60);
        rd_check(8, 32'h9ba35411, "k256_w8");
        rd_check(12, 32'ha8b09c1a, "k256_w12");
        rd_check(59, 32'h706c631e, "k256_w59");

        // Invalid mode: err pulse only, schedule invalidated
        issue(2'd3, rand_key(), p);
        drain();
        check("inv_busy_cycles", busy_cnt, 0);
        check("inv_key_ready", key_ready, 0);
        rd_check(4, 32'h0, "inv_rd_zero");

        // Extra start during expansion, then reset at i=20
        issue(2'd0, rand_key(), p);
        repeat (5) @(negedge clk);
        start = 1'b1; key_len = 2'd3; key_in = rand_key();
        repeat (3) @(negedge clk);
        start = 1'b0; key_len = 2'd0;
        while (cyc < p + 20) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sbq.delete(); dq.delete(); eq.delete();
        exp_valid = 1'b0;
        check_idle_zero("abort");
        busy_cnt = 0;
        repeat (80) @(negedge clk);
        check("abort_busy_cycles", busy_cnt, 0);
        rd_check(43, 32'h0, "abort_rd_zero");
        issue(2'd0, 256'h2b7e151628aed2a6abf7158809cf4f3c << 128, p);
        drain();
        rd_check(43, 32'hb6630ca6, "rerun_w43");

        // Randomized runs with random reads against the model
        for (int r = 0; r < 8; r++) begin
            len = 2'($urandom_range(0, 2));
            issue(len, rand_key(), p);
            drain();
            check("rand_busy_cycles", busy_cnt, 4 * (4 + 2 * int'(len)) + 28);
            for (int k = 0; k < 4; k++) begin
                a = $urandom_range(0, 63);
                rd_check(a, rd_model(a), "rand_rd");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_key_schedule.md
AES_KEY_SCHEDULE -- requirements
Module: aes_key_schedule

Interface
REQ-001 The block SHALL take parameter MAX_KEY_BITS, default 256: the largest key length built in (128, 192 or 256); modes above it are rejected.
REQ-002 The block SHALL take parameter RD_LATENCY, default 1: read-port latency in cycles (1 or 2).
REQ-003 The block SHALL have port clk  input  1  the single clock; all logic is on the rising edge.
REQ-004 The block SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-005 The block SHALL have port start  input  1  request to expand; sampled only in IDLE.
REQ-006 The block SHALL have port key_len  input  2  key length: 00=128, 01=192, 10=256, 11=invalid.
REQ-007 The block SHALL have port key_in  input  256  cipher key, MSB-aligned: 128-bit key in [255:128], 192-bit key in [255:64].
REQ-008 The block SHALL have port busy  output  1  high while expanding.
REQ-009 The block SHALL have port done  output  1  one-cycle pulse on successful completion.
REQ-010 The block SHALL have port err  output  1  one-cycle pulse when a start is rejected.
REQ-011 The block SHALL have port key_ready  output  1  level; schedule storage valid.
REQ-012 The block SHALL have port rk_valid  output  1  streamed word valid.
REQ-013 The block SHALL have port rk_idx  output  6  index i of the streamed word w[i].
REQ-014 The block SHALL have port rk_word  output  32  streamed word w[i].
REQ-015 The block SHALL have port rd_addr  input  6  random-read word index.
REQ-016 The block SHALL have port rd_data  output  32  w[rd_addr], valid RD_LATENCY cycles after rd_addr.

Function
REQ-017 The block SHALL derive Nk = 4/6/8 and TOTAL = 44/52/60 words from key_len, latched at start acceptance.
REQ-018 The FSM SHALL have states IDLE, EXPAND and DONE, with transitions IDLE->EXPAND (valid start), EXPAND->DONE (i = TOTAL-1) and DONE->IDLE (always).
REQ-019 Invalid start SHALL leave the FSM in IDLE; invalid means key_len=11, or key length > MAX_KEY_BITS.
REQ-020 On invalid start, err SHALL pulse on the next cycle, key_ready SHALL clear, and no rk_valid SHALL be emitted.
REQ-021 On valid start accepted at edge T, the block SHALL capture key_in and key_len and clear key_ready; later input changes SHALL have no effect.
REQ-022 In EXPAND, counter i SHALL run from 0 to TOTAL-1, producing exactly one word per cycle.
REQ-023 w[i] SHALL be formed as follows, with temp = w[i-1]:
  - i < Nk: w[i] = key word i, taken from the MSB end.
  - i mod Nk = 0: w[i] = w[i-Nk] ^ SubWord(RotWord(temp)) ^ {Rcon[i/Nk],24'h0}.
  - Nk=8 and i mod 8 = 4: w[i] = w[i-Nk] ^ SubWord(temp).
  - otherwise: w[i] = w[i-Nk] ^ temp.
REQ-024 Rcon[1..10] SHALL be 01,02,04,08,10,20,40,80,1b,36; SubWord SHALL apply the FIPS-197 S-box to each byte.
REQ-025 Each w[i] SHALL be written into a 60x32 storage array and presented on rk_word/rk_idx with rk_valid high during the same cycle.
REQ-026 busy SHALL be high for exactly TOTAL cycles; rk_idx = k SHALL appear in cycle T+1+k.
REQ-027 done SHALL pulse in cycle T+TOTAL+1; key_ready SHALL rise at the same edge and hold until the next accepted start or rst.
REQ-028 start SHALL be ignored while in EXPAND or DONE, with no err.
REQ-029 rd_data SHALL be registered and be 0 when rd_addr >= TOTAL of the last latched mode, or when key_ready = 0.
REQ-030 Storage words above TOTAL SHALL be unspecified, but never visible on rd_data.

Reset
REQ-031 On rst high at a clock edge, the FSM SHALL go to IDLE, i SHALL be 0, and busy, done, err, key_ready and rk_valid SHALL be 0.
REQ-032 On the same reset, rk_idx, rk_word and rd_data SHALL be 0.
REQ-033 Reset mid-EXPAND SHALL abort with no done pulse; the stored words SHALL be unusable until a new expansion completes.
REQ-034 Storage array contents SHALL need no reset.

Verification
REQ-035 AES-128, key 2b7e151628aed2a6abf7158809cf4f3c -> w[4]=a0fafe17, w[43]=b6630ca6, 44 rk_valid cycles, done at T+45.
REQ-036 AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> w[6]=fe0c91f7, w[51]=01002202, done at T+53.
REQ-037 AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> w[8]=9ba35411, w[12]=a8b09c1a, w[59]=706c631e, done at T+61.
REQ-038 Invalid mode: key_len=11 (or key_len=10 with MAX_KEY_BITS=128) -> err pulse at T+1; busy, rk_valid and done stay 0.
REQ-039 start re-asserted during EXPAND, then rst at i=20 -> the extra start is ignored; after reset all outputs are 0 and no done pulse occurs; a fresh AES-128 run then matches REQ-035.
REQ-040 Read port after an AES-128 run -> rd_addr=43 gives b6630ca6 after RD_LATENCY cycles; rd_addr=50 gives 0.
